// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus between the control unit and seq_divider.
interface seq_divider_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle 32-bit non-restoring divider (quotient -> LO, remainder -> HI), one bit per clock.
// Define DIV_SIGNED_EN for signed operands; the default build divides unsigned.
//
// state | meaning
// IDLE  | waiting for start, results held
// SETUP | zero-divisor check, magnitudes and signs captured
// ITER  | 32 shift/add-subtract steps
// FIX   | remainder restore, sign correction, results written
// DONE  | done pulse for one cycle
module seq_divider (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  dif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ITER  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [32:0] p_q, p_d;
  logic [31:0] qr_q, qr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        qsign_q, qsign_d;
  logic        rsign_q, rsign_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic        dbz_q, dbz_d;

  logic [32:0] p_sh;
  logic [32:0] p_new;
  logic [31:0] p_fix;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opa_q   <= '0;
      opb_q   <= '0;
      p_q     <= '0;
      qr_q    <= '0;
      cnt_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      p_q     <= p_d;
      qr_q    <= qr_d;
      cnt_q   <= cnt_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (dif.start) state_d = S_SETUP;
      S_SETUP: state_d = (opb_q == 32'd0) ? S_DONE : S_ITER;
      S_ITER:  if (cnt_q == 6'd31) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // P may wrap in the shift when the divisor uses bit 31; the add/sub result still fits 33 bits.
  always_comb begin
    p_sh  = {p_q[31:0], qr_q[31]};
    p_new = p_q[32] ? (p_sh + {1'b0, opb_q}) : (p_sh - {1'b0, opb_q});
    p_fix = p_q[32] ? (p_q[31:0] + opb_q) : p_q[31:0];
  end

  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    p_d     = p_q;
    qr_d    = qr_q;
    cnt_d   = cnt_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (dif.start) begin
          opa_d = dif.dividend;
          opb_d = dif.divisor;
        end
      end
      S_SETUP: begin
        if (opb_q == 32'd0) begin
          quo_d = 32'hFFFF_FFFF;
          rem_d = opa_q;
          dbz_d = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
          qr_d    = opa_q[31] ? (~opa_q + 32'd1) : opa_q;
          opb_d   = opb_q[31] ? (~opb_q + 32'd1) : opb_q;
          qsign_d = opa_q[31] ^ opb_q[31];
          rsign_d = opa_q[31];
`else
          qr_d    = opa_q;
          qsign_d = 1'b0;
          rsign_d = 1'b0;
`endif
          p_d   = '0;
          cnt_d = '0;
        end
      end
      S_ITER: begin
        p_d   = p_new;
        qr_d  = {qr_q[30:0], ~p_new[32]};
        cnt_d = cnt_q + 6'd1;
      end
      S_FIX: begin
        quo_d = qsign_q ? (~qr_q + 32'd1) : qr_q;
        rem_d = rsign_q ? (~p_fix + 32'd1) : p_fix;
        dbz_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    dif.busy        = (state_q != S_IDLE);
    dif.done        = (state_q == S_DONE);
    dif.quotient    = quo_q;
    dif.remainder   = rem_q;
    dif.div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed handshake/timing cases plus random operands against an arithmetic model.
// Expectations follow DIV_SIGNED_EN the same way the design does.
module tb_seq_divider;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  seq_divider_if dif();

  seq_divider dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division, remainder follows the dividend; 64-bit math makes MIN/-1 wrap naturally.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      z = 1'b0;
`ifdef DIV_SIGNED_EN
      sa = longint'($signed(a));
      sb = longint'($signed(b));
`else
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
`endif
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez,
                        input bit inject);
    int exp_done, done_cnt, done_cyc, busy_cnt, busy_last;
    logic [31:0] q_obs, r_obs;
    logic z_obs;
    exp_done = (b == 32'd0) ? 2 : 35;
    done_cnt = 0; done_cyc = 0; busy_cnt = 0; busy_last = 0;
    q_obs = '0; r_obs = '0; z_obs = 1'b0;
    @(negedge clk);
    dif.start = 1'b1;
    dif.dividend = a;
    dif.divisor = b;
    @(posedge clk);
    for (int k = 1; k <= exp_done + 2; k++) begin
      @(negedge clk);
      if (dif.busy) begin busy_cnt++; busy_last = k; end
      if (dif.done) begin
        done_cnt++;
        done_cyc = k;
        q_obs = dif.quotient;
        r_obs = dif.remainder;
        z_obs = dif.div_by_zero;
      end
      dif.start = inject && (k == 5 || k == 20);
      dif.dividend = $urandom;
      dif.divisor = $urandom;
    end
    check_val({tag, "_done_cnt"}, done_cnt, 1);
    check_val({tag, "_done_cyc"}, done_cyc, exp_done);
    check_val({tag, "_busy_cnt"}, busy_cnt, exp_done);
    check_val({tag, "_busy_last"}, busy_last, exp_done);
    check_val({tag, "_quo"}, q_obs, eq);
    check_val({tag, "_rem"}, r_obs, er);
    check_val({tag, "_dbz"}, 32'(z_obs), 32'(ez));
    check_val({tag, "_quo_held"}, dif.quotient, eq);
    check_val({tag, "_rem_held"}, dif.remainder, er);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"}, 32'(dif.busy), 32'd0);
    check_val({tag, "_done"}, 32'(dif.done), 32'd0);
    check_val({tag, "_quo"}, dif.quotient, 32'd0);
    check_val({tag, "_rem"}, dif.remainder, 32'd0);
    check_val({tag, "_dbz"}, 32'(dif.div_by_zero), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, eq, er;
    logic ez;
    int done_cnt, k_done;

    dif.start = 1'b0;
    dif.dividend = '0;
    dif.divisor = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    reset = 1'b0;

    do_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
`ifdef DIV_SIGNED_EN
    do_div("dm100_7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_div("d100_m7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0);
    do_div("dmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
`else
    do_div("dm100_7", 32'hFFFF_FF9C, 32'd7, 32'h2492_4916, 32'd2, 1'b0, 1'b0);
    do_div("d100_m7", 32'd100, 32'hFFFF_FFF9, 32'd0, 32'd100, 1'b0, 1'b0);
    do_div("dmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
`endif
    do_div("d5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
    do_div("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);
    do_div("inject", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b1);

    // start held high: first op done in cycle 35, idle in 36, re-accepted on edge 36
    @(negedge clk);
    dif.start = 1'b1;
    dif.dividend = 32'd100;
    dif.divisor = 32'd7;
    @(posedge clk);
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      if (k == 35) check_val("hold_done35", 32'(dif.done), 32'd1);
      if (k == 36) check_val("hold_idle36", 32'(dif.busy), 32'd0);
      if (k == 37) check_val("hold_busy37", 32'(dif.busy), 32'd1);
    end
    dif.start = 1'b0;
    k_done = 0;
    for (int k = 38; k <= 80 && k_done == 0; k++) begin
      @(negedge clk);
      if (dif.done) k_done = k;
    end
    check_val("hold_second_done", k_done, 71);
    check_val("hold_second_quo", dif.quotient, 32'd14);
    check_val("hold_second_rem", dif.remainder, 32'd2);

    // reset in cycle 12 of 1000/3 aborts the operation
    @(negedge clk);
    dif.start = 1'b1;
    dif.dividend = 32'd1000;
    dif.divisor = 32'd3;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      dif.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    reset = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dif.done || dif.busy) done_cnt++;
    end
    check_val("midrst_no_activity", done_cnt, 0);
    do_div("after_rst", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0);

    // reset and start together: reset wins
    @(negedge clk);
    reset = 1'b1;
    dif.start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dif.start = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_start");

    for (int i = 0; i < 25; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 17));
        2: b = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
        default: b = $urandom;
      endcase
      if (i % 7 == 3) a = 32'h8000_0000;
      ref_div(a, b, eq, er, ez);
      do_div($sformatf("rnd%0d", i), a, b, eq, er, ez, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
